// File: rtl/rng_pkg.sv
// Shared types and constants for the 64-bit LFSR random-number controller.
package rng_pkg;

  typedef logic [63:0] word_t;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WARMUP   = 2'd2,
    ST_READY    = 2'd3
  } state_e;

  localparam word_t DEFAULT_SEED = 64'hACE1_0000_0000_0001;
  localparam word_t DEFAULT_POLY = 64'hD800_0000_0000_0000;

  // An all-zero seed locks an LFSR and an all-zero mask never feeds back,
  // so both are swapped for a known-good fallback.
  function automatic word_t subst_zero(input word_t v, input word_t dflt);
    return (v == '0) ? dflt : v;
  endfunction

endpackage

// File: rtl/rng_rr_arb.sv
// Round-robin arbiter: combinational one-hot pick starting at the pointer;
// the pointer moves past the winner only when the caller commits the grant.
module rng_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               upd_en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               any_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic          found;

  assign any_o = |req_i;

  // Scan requesters starting at the pointer, first set bit wins.
  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx      = PW'(j);
        found    = 1'b1;
      end
    end
    ptr_d = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  end

  // Pointer only advances on a committed grant; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (!rst_n)                 ptr_q <= '0;
    else if (upd_en_i && found) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rng_64_ctrl.sv
// Controller for a shared external 64-bit LFSR: seeds it, discards a warm-up
// run, then hands words to requesters round-robin with a minimum spacing so
// no two delivered words overlap in LFSR bits.
module rng_64_ctrl
  import rng_pkg::word_t, rng_pkg::state_e, rng_pkg::subst_zero,
         rng_pkg::ST_UNSEEDED, rng_pkg::ST_LOAD, rng_pkg::ST_WARMUP, rng_pkg::ST_READY;
#(
  parameter int          NUM_REQ       = 4,
  parameter int          WARMUP_CYCLES = 128,
  parameter int          GAP_CYCLES    = 64,
  parameter logic [63:0] DEFAULT_SEED  = rng_pkg::DEFAULT_SEED,
  parameter logic [63:0] DEFAULT_POLY  = rng_pkg::DEFAULT_POLY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_seed_valid_i,
  input  logic [63:0]        cfg_seed_i,
  input  logic [63:0]        cfg_poly_i,
  output logic               cfg_seed_ready_o,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [63:0]        rnd_o,
  output logic               lfsr_load_o,
  output logic [63:0]        lfsr_seed_o,
  output logic [63:0]        lfsr_poly_o,
  input  logic [63:0]        lfsr_data_i,
  input  logic               lfsr_valid_i,
  output logic               ready_o,
  output logic               seed_err_o
);

  localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);

  state_e          state_q, state_d;
  word_t           seed_q, seed_d, poly_q, poly_d;
  logic            err_q, err_d;
  logic [WW-1:0]   warm_q, warm_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            accept, grant, any_req;
  logic [NUM_REQ-1:0] arb_gnt;

  rng_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .upd_en_i (grant),
    .gnt_o    (arb_gnt),
    .any_o    (any_req)
  );

  assign cfg_seed_ready_o = (state_q == ST_UNSEEDED) || (state_q == ST_READY);
  assign accept           = cfg_seed_valid_i && cfg_seed_ready_o;
  // A reload in the same cycle wins over the grant; the request just waits.
  assign grant = (state_q == ST_READY) && (gap_q == '0) && lfsr_valid_i &&
                 any_req && !accept;

  assign gnt_o       = grant ? arb_gnt : '0;
  assign rnd_o       = grant ? lfsr_data_i : '0;
  assign lfsr_load_o = (state_q == ST_LOAD);
  assign lfsr_seed_o = seed_q;
  assign lfsr_poly_o = poly_q;
  assign ready_o     = (state_q == ST_READY);
  assign seed_err_o  = err_q;

  // Next-state: reload capture, warm-up counting and grant spacing.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    poly_d  = poly_q;
    err_d   = err_q;
    warm_d  = warm_q;
    gap_d   = gap_q;
    if (accept) begin
      seed_d  = subst_zero(cfg_seed_i, DEFAULT_SEED);
      poly_d  = subst_zero(cfg_poly_i, DEFAULT_POLY);
      err_d   = (cfg_seed_i == '0) || (cfg_poly_i == '0);
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          state_d = ST_WARMUP;
          warm_d  = '0;
        end
        ST_WARMUP: begin
          if (lfsr_valid_i) begin
            if (warm_q == WARM_LAST) begin
              state_d = ST_READY;
              gap_d   = '0;
            end else begin
              warm_d = warm_q + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (grant)             gap_d = GAP_LOAD;
          else if (gap_q != '0) gap_d = gap_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_UNSEEDED;
      seed_q  <= '0;
      poly_q  <= DEFAULT_POLY;
      err_q   <= 1'b0;
      warm_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      poly_q  <= poly_d;
      err_q   <= err_d;
      warm_q  <= warm_d;
      gap_q   <= gap_d;
    end
  end

endmodule
